// File: rtl/riscv_pkg.sv
// Shared definitions for the multicycle RV32I core: opcodes, extend-unit
// select codes, ALU control codes and the controller state set.
// The immediate-select encoding must match the extend unit.
package riscv_pkg;

  localparam logic [6:0] OP_LW    = 7'b0000011;
  localparam logic [6:0] OP_SW    = 7'b0100011;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  typedef enum logic [2:0] {
    IMM_I = 3'b000,
    IMM_S = 3'b001,
    IMM_B = 3'b010,
    IMM_J = 3'b011,
    IMM_U = 3'b100
  } imm_src_t;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_XOR = 3'b100,
    ALU_SLT = 3'b101
  } alu_ctrl_t;

  // ALUOp: what the FSM asks of the ALU decoder
  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } alu_op_t;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMREAD,
    S_MEMWB,
    S_MEMWRITE,
    S_EXECUTER,
    S_EXECUTEI,
    S_AUIPC,
    S_ALUWB,
    S_BEQ,
    S_JAL,
    S_LUIWB,
    S_TRAP
  } mc_state_t;

  // Immediate format implied by the opcode; unknown opcodes select I
  function automatic imm_src_t imm_sel(input logic [6:0] op);
    imm_src_t sel;
    case (op)
      OP_SW:            sel = IMM_S;
      OP_BEQ:           sel = IMM_B;
      OP_JAL:           sel = IMM_J;
      OP_LUI, OP_AUIPC: sel = IMM_U;
      default:          sel = IMM_I;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/multicycle_controller_alu_decoder.sv
// ALU decoder: turns the FSM's ALUOp plus the instruction funct fields
// into the 3-bit ALU operation select.
module alu_decoder
  import riscv_pkg::*;
(
  input  logic [1:0] ALUOp,
  input  logic [2:0] funct3,
  input  logic       op5,
  input  logic       funct7b5,
  output logic [2:0] ALUControl
);

  alu_ctrl_t ctrl;

  // Select the ALU operation; only R-type (op5=1) can request subtract
  always_comb begin
    ctrl = ALU_ADD;
    case (ALUOp)
      ALUOP_SUB:   ctrl = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct3)
          3'b000:  ctrl = (op5 & funct7b5) ? ALU_SUB : ALU_ADD;
          3'b010:  ctrl = ALU_SLT;
          3'b100:  ctrl = ALU_XOR;
          3'b110:  ctrl = ALU_OR;
          3'b111:  ctrl = ALU_AND;
          default: ctrl = ALU_ADD;
        endcase
      end
      default:     ctrl = ALU_ADD;
    endcase
  end

  assign ALUControl = ctrl;

endmodule

// File: rtl/multicycle_controller.sv
// Control FSM for the multicycle RV32I core (Moore, plus the branch term
// on PCWrite and opcode-driven ImmSrc).
// Optional feature: define CTRL_ILLEGAL_TRAP_EN to trap unknown opcodes
// into a sticky TRAP state flagged on the illegal output.
module multicycle_controller
  import riscv_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       Zero,
  output logic [2:0] ImmSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ALUControl,
  output logic [1:0] ResultSrc,
  output logic       AdrSrc,
  output logic       IRWrite,
  output logic       PCWrite,
  output logic       RegWrite,
  output logic       MemWrite
`ifdef CTRL_ILLEGAL_TRAP_EN
  ,
  output logic       illegal
`endif
);

  mc_state_t state, next_state;
  alu_op_t   aluop;
  logic      irw, pcupdate, branch, rw, mw;

  // State register; reset returns to FETCH immediately
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_FETCH;
    else          state <= next_state;
  end

  // Next-state and per-state control decode
  always_comb begin
    next_state = state;
    ALUSrcA    = 2'b00;
    ALUSrcB    = 2'b00;
    aluop      = ALUOP_ADD;
    ResultSrc  = 2'b00;
    AdrSrc     = 1'b0;
    irw        = 1'b0;
    pcupdate   = 1'b0;
    branch     = 1'b0;
    rw         = 1'b0;
    mw         = 1'b0;
    case (state)
      S_FETCH: begin
        irw        = 1'b1;
        ALUSrcB    = 2'b10;
        ResultSrc  = 2'b10;
        pcupdate   = 1'b1;
        next_state = S_DECODE;
      end
      S_DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
        case (op)
          OP_LW, OP_SW: next_state = S_MEMADR;
          OP_R:         next_state = S_EXECUTER;
          OP_I:         next_state = S_EXECUTEI;
          OP_BEQ:       next_state = S_BEQ;
          OP_JAL:       next_state = S_JAL;
          OP_LUI:       next_state = S_LUIWB;
          OP_AUIPC:     next_state = S_AUIPC;
`ifdef CTRL_ILLEGAL_TRAP_EN
          default:      next_state = S_TRAP;
`else
          default:      next_state = S_FETCH;
`endif
        endcase
      end
      S_MEMADR: begin
        ALUSrcA    = 2'b10;
        ALUSrcB    = 2'b01;
        next_state = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        AdrSrc     = 1'b1;
        next_state = S_MEMWB;
      end
      S_MEMWB: begin
        ResultSrc  = 2'b01;
        rw         = 1'b1;
        next_state = S_FETCH;
      end
      S_MEMWRITE: begin
        AdrSrc     = 1'b1;
        mw         = 1'b1;
        next_state = S_FETCH;
      end
      S_EXECUTER: begin
        ALUSrcA    = 2'b10;
        aluop      = ALUOP_FUNCT;
        next_state = S_ALUWB;
      end
      S_EXECUTEI: begin
        ALUSrcA    = 2'b10;
        ALUSrcB    = 2'b01;
        aluop      = ALUOP_FUNCT;
        next_state = S_ALUWB;
      end
      S_AUIPC: begin
        ALUSrcA    = 2'b01;
        ALUSrcB    = 2'b01;
        next_state = S_ALUWB;
      end
      S_ALUWB: begin
        rw         = 1'b1;
        next_state = S_FETCH;
      end
      S_BEQ: begin
        ALUSrcA    = 2'b10;
        aluop      = ALUOP_SUB;
        branch     = 1'b1;
        next_state = S_FETCH;
      end
      S_JAL: begin
        ALUSrcA    = 2'b01;
        ALUSrcB    = 2'b10;
        pcupdate   = 1'b1;
        next_state = S_ALUWB;
      end
      S_LUIWB: begin
        ResultSrc  = 2'b11;
        rw         = 1'b1;
        next_state = S_FETCH;
      end
      S_TRAP:  next_state = S_TRAP;
      default: next_state = S_FETCH;
    endcase
  end

  alu_decoder u_alu_decoder (
    .ALUOp      (aluop),
    .funct3     (funct3),
    .op5        (op[5]),
    .funct7b5   (funct7b5),
    .ALUControl (ALUControl)
  );

  assign ImmSrc = imm_sel(op);

  // Write enables are gated by reset_n so nothing commits while reset is held
  assign IRWrite  = irw & reset_n;
  assign PCWrite  = (pcupdate | (branch & Zero)) & reset_n;
  assign RegWrite = rw & reset_n;
  assign MemWrite = mw & reset_n;

`ifdef CTRL_ILLEGAL_TRAP_EN
  assign illegal = (state == S_TRAP);
`endif

endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Control FSM for the multicycle RV32I core. It sequences the shared ALU, memory port, register file and immediate extend unit across the Fetch, Decode, Execute, Memory and Writeback steps of each instruction. It also drives the extend unit's 3-bit immediate-select code from the instruction opcode. It sits beside the datapath and observes only the opcode fields and the ALU Zero flag.

## Interface
- No parameters.
- `clk` in 1: single core clock, rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `op` in 7: instruction bits [6:0] from the instruction register.
- `funct3` in 3: instruction bits [14:12].
- `funct7b5` in 1: instruction bit 30.
- `Zero` in 1: ALU result == 0.
- `ImmSrc` out 3: extend select. 000 I, 001 S, 010 B, 011 J, 100 U.
- `ALUSrcA` out 2: 00 PC, 01 OldPC, 10 rs1 register.
- `ALUSrcB` out 2: 00 rs2 register, 01 ImmExt, 10 constant 4.
- `ALUControl` out 3: 000 add, 001 sub, 010 and, 011 or, 100 xor, 101 slt.
- `ResultSrc` out 2: 00 ALUOut, 01 read data, 10 ALUResult, 11 ImmExt.
- `AdrSrc` out 1: 0 PC, 1 Result.
- `IRWrite`, `PCWrite`, `RegWrite`, `MemWrite` out 1 each: write enables.
- `illegal` out 1: present only with `CTRL_ILLEGAL_TRAP_EN` (see Configuration).

## Operation
- Moore FSM. All outputs decode from the state, except:
  - `PCWrite` = PCUpdate | (Branch & Zero).
  - `ImmSrc` decodes combinationally from `op`: lw/I-ALU/jalr I, sw S, beq B, jal J, lui/auipc U, anything else 000.
- Opcodes handled: lw 0000011, sw 0100011, R 0110011, I-ALU 0010011, beq 1100011, jal 1101111, lui 0110111, auipc 0010111.
- FETCH: AdrSrc=0, IRWrite=1, ALUSrcA=00, ALUSrcB=10, add, ResultSrc=10, PCUpdate=1. Next state DECODE.
- DECODE: ALUSrcA=01, ALUSrcB=01, add (precomputes branch target). Next state by op:
  - lw/sw → MEMADR
  - R → EXECUTER
  - I-ALU → EXECUTEI
  - beq → BEQ
  - jal → JAL
  - lui → LUIWB
  - auipc → AUIPC
  - other → FETCH
- MEMADR: ALUSrcA=10, ALUSrcB=01, add. Next state MEMREAD for lw, MEMWRITE for sw.
- MEMREAD: ResultSrc=00, AdrSrc=1. Next state MEMWB.
- MEMWB: ResultSrc=01, RegWrite=1. Next state FETCH.
- MEMWRITE: ResultSrc=00, AdrSrc=1, MemWrite=1. Next state FETCH.
- EXECUTER: ALUSrcA=10, ALUSrcB=00, funct decode. Next state ALUWB.
- EXECUTEI: ALUSrcA=10, ALUSrcB=01, funct decode. Next state ALUWB.
- AUIPC: ALUSrcA=01, ALUSrcB=01, add. Next state ALUWB.
- ALUWB: ResultSrc=00, RegWrite=1. Next state FETCH.
- BEQ: ALUSrcA=10, ALUSrcB=00, sub, ResultSrc=00, Branch=1. Next state FETCH.
- JAL: ALUSrcA=01, ALUSrcB=10, add, ResultSrc=00, PCUpdate=1. Next state ALUWB.
- LUIWB: ResultSrc=11, RegWrite=1. Next state FETCH.
- Funct decode by funct3:
  - 000: sub if op[5] & funct7b5, else add (addi always adds).
  - 010 → slt; 100 → xor; 110 → or; 111 → and; others → add.
- Don't-care outputs are driven to 0 in every state.

## Timing
- Cycles per instruction, FETCH through return to FETCH: lw 5, sw 4, R 4, I-ALU 4, auipc 4, jal 4, beq 3, lui 3, unknown opcode 2.
- State register updates on rising `clk`. `reset_n` low forces FETCH immediately (asynchronously).
- While `reset_n` is low, IRWrite, PCWrite, RegWrite and MemWrite are forced to 0. All other outputs hold their FETCH values.
- Reset deasserted mid-instruction: execution restarts at FETCH with no partial writes.
- In BEQ, `Zero` is sampled combinationally in the same cycle. `PCWrite` may toggle within that cycle and must be stable by the clock edge.

## Configuration
- `CTRL_ILLEGAL_TRAP_EN` defined:
  - An unknown opcode in DECODE moves to state TRAP.
  - In TRAP, all write enables are 0 and `illegal`=1. TRAP is held until reset.
- Not defined:
  - The `illegal` port is absent.
  - An unknown opcode returns to FETCH and behaves as a nop.

## Structure
- Shared package `riscv_pkg` holds:
  - opcode constants;
  - the `imm_src_t` enum (values must match the extend unit's encoding);
  - the `alu_ctrl_t` enum;
  - the `mc_state_t` FSM enum.
- One sub-module, `alu_decoder`: combinational (ALUOp[1:0], funct3, op[5], funct7b5) → ALUControl.
- The main FSM, next-state logic and output decode live in `multicycle_controller`.

## Test plan
- Reset: hold `reset_n`=0, then release. Expect state FETCH, IRWrite=1 on the first clock, and no RegWrite/MemWrite.
- lw (op=0000011): ImmSrc=000, 5-cycle sequence. MEMREAD has AdrSrc=1; MEMWB has RegWrite=1 and ResultSrc=01.
- sw: ImmSrc=001, MemWrite=1 in cycle 4 only. R-type sub (funct3=000, funct7b5=1): ALUControl=001 in EXECUTER.
- beq: ImmSrc=010. With Zero=1, PCWrite=1 in BEQ; with Zero=0, PCWrite=0. Both cases return to FETCH after 3 cycles.
- jal: ImmSrc=011, PCWrite=1 in JAL. lui: ImmSrc=100, ResultSrc=11, RegWrite=1 in cycle 3.
- Unknown op 1111111: returns to FETCH after DECODE, or with `CTRL_ILLEGAL_TRAP_EN`, `illegal`=1 held until a `reset_n` pulse.
